// File: rtl/delay_timer_bank.sv
// delay_timer_bank: CH independent one-shot/periodic down-counter timers sharing period select, pause and bgState.
// Latency: expiry P clocks after the accepting edge (plus one per paused cycle); tick is a registered 1-cycle pulse.
// No backpressure; define DELAY_STATE_GATE_EN to accept starts only while bgState==ARM_STATE.
module delay_timer_bank #(
  parameter int              CH            = 4,
  parameter int              W             = 26,
  parameter logic [W-1:0]    DEFAULT_DELAY = W'(20_000_000),
  parameter logic [2:0]      ARM_STATE     = 3'd2
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic [CH-1:0] start,
  input  logic [CH-1:0] stop,
  input  logic [CH-1:0] periodic,
  input  logic          use_load,
  input  logic [W-1:0]  load_val,
  input  logic          pause,
  input  logic [2:0]    bgState,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0]  p_raw;
  logic [W-1:0]  p_eff;
  logic [CH-1:0] start_acc;

  // A zero period would never expire; it behaves as a one-clock delay.
  assign p_raw = use_load ? load_val : DEFAULT_DELAY;
  assign p_eff = (p_raw == '0) ? ONE : p_raw;

`ifdef DELAY_STATE_GATE_EN
  assign start_acc = (bgState == ARM_STATE) ? start : '0;
`else
  logic unused_gate;
  assign unused_gate = ^{bgState, ARM_STATE};
  assign start_acc   = start;
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] per_q, per_d;
    logic         mode_q, mode_d;
    logic         tick_q, tick_d;

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        per_q   <= '0;
        mode_q  <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        per_q   <= per_d;
        mode_q  <= mode_d;
        tick_q  <= tick_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      mode_d  = mode_q;
      tick_d  = 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
        end
        ST_RUN: begin
          if (!pause) begin
            if (cnt_q <= ONE) begin
              tick_d = 1'b1;
              if (mode_q) begin
                cnt_d = per_q;
              end else begin
                state_d = ST_DONE;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        ST_DONE: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      // Priority: stop over start over expiry; neither start nor stop emits a tick.
      if (start_acc[g]) begin
        state_d = ST_RUN;
        cnt_d   = p_eff;
        per_d   = p_eff;
        mode_d  = periodic[g];
        tick_d  = 1'b0;
      end

      if (stop[g]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tick_d  = 1'b0;
      end
    end

    assign busy[g] = (state_q == ST_RUN);
    assign dout[g] = (state_q == ST_DONE);
    assign tick[g] = tick_q;
  end

endmodule

// File: tb/tb_delay_timer_bank.sv
// Directed-vector bench for delay_timer_bank; expected tick edges are queued per channel and a monitor checks them.
module tb_delay_timer_bank;

  localparam int CH = 4;
  localparam int W  = 26;

  logic          clk;
  logic          resetN;
  logic [CH-1:0] start;
  logic [CH-1:0] stop;
  logic [CH-1:0] periodic;
  logic          use_load;
  logic [W-1:0]  load_val;
  logic          pause;
  logic [2:0]    bgState;
  logic [CH-1:0] dout;
  logic [CH-1:0] tick;
  logic [CH-1:0] busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q [CH][$];

  delay_timer_bank #(
    .CH(CH), .W(W), .DEFAULT_DELAY(W'(20_000_000)), .ARM_STATE(3'd2)
  ) dut (
    .clk(clk), .resetN(resetN), .start(start), .stop(stop), .periodic(periodic),
    .use_load(use_load), .load_val(load_val), .pause(pause), .bgState(bgState),
    .dout(dout), .tick(tick), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_tick ch%0d: no tick seen, required at edge %0d", c, exp_q[c][0]);
        void'(exp_q[c].pop_front());
      end
      if (tick[c] === 1'b1) begin
        checks++;
        if (exp_q[c].size() == 0) begin
          errors++;
          $display("FAIL extra_tick ch%0d: tick at edge %0d, none expected", c, cyc);
        end else begin
          int e;
          e = exp_q[c].pop_front();
          if (e != cyc) begin
            errors++;
            $display("FAIL tick_edge ch%0d: tick at edge %0d, required %0d", c, cyc, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge k (cyc==k).
  task automatic do_start(input int ch, input bit per, input int p, input int n);
    int k;
    start[ch]    = 1'b1;
    periodic[ch] = per;
    k = cyc + 1;
    for (int j = 1; j <= n; j++) exp_q[ch].push_back(k + p * j);
    @(negedge clk);
    start[ch] = 1'b0;
  endtask

  task automatic do_stop(input int ch);
    stop[ch] = 1'b1;
    @(negedge clk);
    stop[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gated;
`ifdef DELAY_STATE_GATE_EN
    gated = 1'b1;
`else
    gated = 1'b0;
`endif
    resetN = 1'b0; start = '0; stop = '0; periodic = '0;
    use_load = 1'b1; load_val = '0; pause = 1'b0; bgState = 3'd2;
    step(3);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_dout", 32'(dout), 0);
    chk("reset_tick", 32'(tick), 0);
    resetN = 1'b1;
    step(2);

    // One-shot ch0, P=5: busy for 5 edges, then DONE with a single tick.
    load_val = 5;
    do_start(0, 1'b0, 5, 1);
    for (int i = 0; i < 5; i++) begin
      chk("oneshot_busy", 32'(busy[0]), 1);
      chk("oneshot_dout_low", 32'(dout[0]), 0);
      step(1);
    end
    chk("oneshot_done", 32'(dout[0]), 1);
    chk("oneshot_busy_off", 32'(busy[0]), 0);
    step(3);
    chk("done_persists", 32'(dout[0]), 1);
    do_stop(0);
    chk("stop_clears_done", 32'(dout[0]), 0);

    // bgState outside the arm state: start on ch1 is dropped only when gated.
    bgState = 3'd1;
    do_start(1, 1'b0, 5, gated ? 0 : 1);
    chk("gate_busy", 32'(busy[1]), gated ? 0 : 1);
    bgState = 3'd2;
    step(7);
    chk("gate_dout", 32'(dout[1]), gated ? 0 : 1);
    do_stop(1);

    // Periodic ch2, P=3: four ticks, then stop.
    load_val = 3;
    do_start(2, 1'b1, 3, 4);
    step(12);
    chk("periodic_still_busy", 32'(busy[2]), 1);
    do_stop(2);
    chk("periodic_stopped", 32'(busy[2]), 0);
    step(6);
    chk("periodic_idle", 32'(busy[2] | dout[2]), 0);

    // Pause for two edges stretches P=4 to 6 clocks.
    load_val = 4;
    do_start(3, 1'b0, 6, 1);
    step(1);
    pause = 1'b1;
    step(2);
    chk("pause_hold_busy", 32'(busy[3]), 1);
    pause = 1'b0;
    step(5);
    chk("pause_done", 32'(dout[3]), 1);

    // Zero load value behaves as a one-clock delay; rearm clears dout.
    load_val = 0;
    do_start(3, 1'b0, 1, 1);
    chk("rearm_dout_clear", 32'(dout[3]), 0);
    chk("p0_busy", 32'(busy[3]), 1);
    step(1);
    chk("p0_done", 32'(dout[3]), 1);
    do_stop(3);

    // Start and stop together while running: stop wins, no tick.
    load_val = 10;
    do_start(0, 1'b0, 10, 0);
    step(2);
    start[0] = 1'b1; stop[0] = 1'b1;
    step(1);
    start[0] = 1'b0; stop[0] = 1'b0;
    chk("start_stop_idle", 32'(busy[0] | dout[0]), 0);
    step(12);

    // Retrigger on the expiry edge: no tick, full reload.
    load_val = 4;
    do_start(1, 1'b0, 4, 0);
    step(3);
    do_start(1, 1'b0, 4, 1);
    chk("retrig_busy", 32'(busy[1]), 1);
    step(4);
    chk("retrig_done", 32'(dout[1]), 1);
    do_stop(1);

    // Reset at cnt==2 aborts at once; no tick after release.
    load_val = 5;
    do_start(0, 1'b0, 5, 0);
    step(3);
    #1 resetN = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_dout", 32'(dout), 0);
    chk("arst_tick", 32'(tick), 0);
    step(2);
    // Start held at release is evaluated on the first edge.
    load_val = 2;
    resetN = 1'b1;
    do_start(2, 1'b0, 2, 1);
    chk("post_rst_busy0", 32'(busy[0]), 0);
    chk("post_rst_busy2", 32'(busy[2]), 1);
    step(8);
    chk("post_rst_done2", 32'(dout[2]), 1);

    step(4);
    for (int c = 0; c < CH; c++) chk("queue_drained", 32'(exp_q[c].size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
